// File: rtl/cmp_result_tracker.sv
// Result tracker for the single-bit comparator stage: saturating per-outcome counters,
// run-length tracking, sticky malformed-result flag and a req/ack snapshot port.
module cmp_result_tracker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned RUN_THR     = 4,
  parameter bit          CLR_ON_SNAP = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  input  logic             i_gt,
  input  logic             i_ls,
  input  logic             i_eq,
  input  logic             i_clr,
  input  logic             i_snap_req,
  input  logic             i_snap_ready,
  output logic [CNT_W-1:0] o_gt_cnt,
  output logic [CNT_W-1:0] o_ls_cnt,
  output logic [CNT_W-1:0] o_eq_cnt,
  output logic             o_snap_valid,
  output logic [CNT_W-1:0] o_run_len,
  output logic             o_run_hit,
  output logic             o_err
);

  typedef enum logic [1:0] {ClsNone, ClsGt, ClsLs, ClsEq} cls_e;
  typedef enum logic {StIdle, StHold} snap_st_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] RunThr = CNT_W'(RUN_THR);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  logic [CNT_W-1:0] r_gt_live, r_ls_live, r_eq_live;
  logic [CNT_W-1:0] r_gt_snap, r_ls_snap, r_eq_snap;
  logic [CNT_W-1:0] r_run_len;
  cls_e             r_cls;
  logic             r_run_hit;
  logic             r_err;
  snap_st_e         r_state;
  logic             r_snap_valid;

  logic [1:0]       w_flag_cnt;
  logic             w_one_hot;
  logic             w_accept;
  logic             w_malformed;
  logic             w_capture;
  cls_e             w_cls_in;
  cls_e             w_cls_next;
  logic [CNT_W-1:0] w_gt_next, w_ls_next, w_eq_next;
  logic [CNT_W-1:0] w_run_len_next;

  assign w_flag_cnt  = {1'b0, i_gt} + {1'b0, i_ls} + {1'b0, i_eq};
  assign w_one_hot   = (w_flag_cnt == 2'd1);
  // clr wins over a same-cycle sample
  assign w_accept    = i_in_valid & w_one_hot & ~i_clr;
  assign w_malformed = i_in_valid & ~w_one_hot;
  assign w_capture   = (r_state == StIdle) & i_snap_req;

  always_comb begin
    w_cls_in = ClsNone;
    if (i_gt)      w_cls_in = ClsGt;
    else if (i_ls) w_cls_in = ClsLs;
    else if (i_eq) w_cls_in = ClsEq;
  end

  always_comb begin
    w_gt_next = r_gt_live;
    w_ls_next = r_ls_live;
    w_eq_next = r_eq_live;
    if (i_clr) begin
      w_gt_next = '0;
      w_ls_next = '0;
      w_eq_next = '0;
    end else if (w_accept) begin
      unique case (w_cls_in)
        ClsGt:   w_gt_next = sat_inc(r_gt_live);
        ClsLs:   w_ls_next = sat_inc(r_ls_live);
        ClsEq:   w_eq_next = sat_inc(r_eq_live);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cls_next     = r_cls;
    w_run_len_next = r_run_len;
    if (i_clr) begin
      w_cls_next     = ClsNone;
      w_run_len_next = '0;
    end else if (w_accept) begin
      w_cls_next = w_cls_in;
      if (w_cls_in == r_cls) w_run_len_next = sat_inc(r_run_len);
      else                   w_run_len_next = CntOne;
    end
  end

  // Snapshot capture may zero the live counters; the same-cycle sample lands in the snapshot only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gt_live <= '0;
      r_ls_live <= '0;
      r_eq_live <= '0;
    end else if (CLR_ON_SNAP && w_capture) begin
      r_gt_live <= '0;
      r_ls_live <= '0;
      r_eq_live <= '0;
    end else begin
      r_gt_live <= w_gt_next;
      r_ls_live <= w_ls_next;
      r_eq_live <= w_eq_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gt_snap <= '0;
      r_ls_snap <= '0;
      r_eq_snap <= '0;
    end else if (w_capture) begin
      r_gt_snap <= w_gt_next;
      r_ls_snap <= w_ls_next;
      r_eq_snap <= w_eq_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cls     <= ClsNone;
      r_run_len <= '0;
      r_run_hit <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cls     <= w_cls_next;
      r_run_len <= w_run_len_next;
      r_run_hit <= (w_run_len_next >= RunThr);
      r_err     <= i_clr ? 1'b0 : (r_err | w_malformed);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_snap_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_snap_req) begin
            r_state      <= StHold;
            r_snap_valid <= 1'b1;
          end
        end
        StHold: begin
          if (i_snap_ready) begin
            r_state      <= StIdle;
            r_snap_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_snap_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_gt_cnt     = r_gt_snap;
  assign o_ls_cnt     = r_ls_snap;
  assign o_eq_cnt     = r_eq_snap;
  assign o_snap_valid = r_snap_valid;
  assign o_run_len    = r_run_len;
  assign o_run_hit    = r_run_hit;
  assign o_err        = r_err;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker: two instances (CLR_ON_SNAP 0 and 1) on shared stimulus,
// checked every cycle against an integer-arithmetic reference model.
module tb_cmp_result_tracker;

  localparam int CNT_MAX = 255;
  localparam int THR     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, gt = 1'b0, ls = 1'b0, eq = 1'b0;
  logic clr = 1'b0, snap_req = 1'b0, snap_ready = 1'b0;

  logic [7:0] d0_gt, d0_ls, d0_eq, d0_len, d1_gt, d1_ls, d1_eq, d1_len;
  logic       d0_sv, d0_hit, d0_err, d1_sv, d1_hit, d1_err;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = gt, 1 = ls, 2 = eq; class -1 = none.
  int m_cnt[2][3];
  int m_snap[2][3];
  bit m_hold;
  int m_len;
  int m_cls;
  bit m_err;

  always #5 clk = ~clk;

  cmp_result_tracker #(.CNT_W(8), .RUN_THR(THR), .CLR_ON_SNAP(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_gt(gt), .i_ls(ls), .i_eq(eq),
    .i_clr(clr), .i_snap_req(snap_req), .i_snap_ready(snap_ready),
    .o_gt_cnt(d0_gt), .o_ls_cnt(d0_ls), .o_eq_cnt(d0_eq), .o_snap_valid(d0_sv),
    .o_run_len(d0_len), .o_run_hit(d0_hit), .o_err(d0_err)
  );

  cmp_result_tracker #(.CNT_W(8), .RUN_THR(THR), .CLR_ON_SNAP(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_gt(gt), .i_ls(ls), .i_eq(eq),
    .i_clr(clr), .i_snap_req(snap_req), .i_snap_ready(snap_ready),
    .o_gt_cnt(d1_gt), .o_ls_cnt(d1_ls), .o_eq_cnt(d1_eq), .o_snap_valid(d1_sv),
    .o_run_len(d1_len), .o_run_hit(d1_hit), .o_err(d1_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) begin
        m_cnt[k][c]  = 0;
        m_snap[k][c] = 0;
      end
    m_hold = 0;
    m_len  = 0;
    m_cls  = -1;
    m_err  = 0;
  endtask

  task automatic model_step(input bit v, g, l, e, c, rq, rd);
    int  nflags, cls;
    bit  acc, bad, cap;
    int  nxt[2][3];
    nflags = int'(g) + int'(l) + int'(e);
    cls    = g ? 0 : (l ? 1 : 2);
    acc    = v && nflags == 1 && !c;
    bad    = v && nflags != 1;
    cap    = !m_hold && rq;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) begin
        if (c) nxt[k][j] = 0;
        else if (acc && cls == j) nxt[k][j] = (m_cnt[k][j] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[k][j] + 1;
        else nxt[k][j] = m_cnt[k][j];
        if (cap) m_snap[k][j] = nxt[k][j];
        m_cnt[k][j] = (cap && k == 1) ? 0 : nxt[k][j];
      end
    if (cap) m_hold = 1;
    else if (m_hold && rd) m_hold = 0;
    if (c) begin
      m_len = 0;
      m_cls = -1;
    end else if (acc) begin
      if (cls == m_cls) m_len = (m_len + 1 > CNT_MAX) ? CNT_MAX : m_len + 1;
      else m_len = 1;
      m_cls = cls;
    end
    m_err = c ? 1'b0 : (m_err | bad);
  endtask

  task automatic check_all();
    check("snap_valid0", 32'(d0_sv), 32'(m_hold));
    check("snap_valid1", 32'(d1_sv), 32'(m_hold));
    check("run_len0", 32'(d0_len), m_len);
    check("run_len1", 32'(d1_len), m_len);
    check("run_hit0", 32'(d0_hit), 32'(m_len >= THR));
    check("run_hit1", 32'(d1_hit), 32'(m_len >= THR));
    check("err0", 32'(d0_err), 32'(m_err));
    check("err1", 32'(d1_err), 32'(m_err));
    check("gt_cnt0", 32'(d0_gt), m_snap[0][0]);
    check("ls_cnt0", 32'(d0_ls), m_snap[0][1]);
    check("eq_cnt0", 32'(d0_eq), m_snap[0][2]);
    check("gt_cnt1", 32'(d1_gt), m_snap[1][0]);
    check("ls_cnt1", 32'(d1_ls), m_snap[1][1]);
    check("eq_cnt1", 32'(d1_eq), m_snap[1][2]);
  endtask

  task automatic step(input bit v, g, l, e, c, rq, rd);
    in_valid = v; gt = g; ls = l; eq = e; clr = c; snap_req = rq; snap_ready = rd;
    model_step(v, g, l, e, c, rq, rd);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit [2:0] f;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Counts 3 gt, 2 eq, 1 ls then snapshot and release
    repeat (3) step(1, 1, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("first_snap_gt", 32'(d0_gt), 3);
    check("first_snap_eq", 32'(d0_eq), 2);
    check("first_snap_ls", 32'(d0_ls), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("first_snap_released", 32'(d0_sv), 0);

    // Run of eq crossing the threshold, broken by gt
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 1, 0, 0, 0);
      check("eq_run_len", 32'(d0_len), i);
    end
    step(1, 1, 0, 0, 0, 0, 0);
    check("run_break_len", 32'(d0_len), 1);
    check("run_break_hit", 32'(d0_hit), 0);

    // Malformed results, then clear
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("err_sticky", 32'(d0_err), 1);
    check("err_len_kept", 32'(d0_len), 1);
    step(1, 1, 0, 0, 1, 0, 0);
    check("clr_err", 32'(d0_err), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("clr_snap_gt", 32'(d0_gt), 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Saturation at 255
    repeat (257) step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("sat_ls_cnt", 32'(d0_ls), 255);
    check("sat_run_len", 32'(d0_len), 255);
    step(0, 0, 0, 0, 0, 0, 1);

    // Capture with same-cycle sample, HOLD ignores further requests
    step(0, 0, 0, 0, 1, 0, 0);
    repeat (6) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    check("same_cycle_gt0", 32'(d0_gt), 7);
    check("same_cycle_gt1", 32'(d1_gt), 7);
    step(1, 1, 0, 0, 0, 1, 0);
    check("hold_frozen_gt0", 32'(d0_gt), 7);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    check("resnap_gt0", 32'(d0_gt), 8);
    check("resnap_gt1_cleared", 32'(d1_gt), 1);

    // Asynchronous reset while holding a snapshot mid-run
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_snap_valid", 32'(d0_sv), 0);
    check("rst_run_hit", 32'(d0_hit), 0);
    check("rst_gt_cnt", 32'(d0_gt), 0);
    check("rst_gt_cnt1", 32'(d1_gt), 0);
    in_valid = 0; gt = 0; ls = 0; eq = 0; clr = 0; snap_req = 0; snap_ready = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 1, 0, 0, 0);
    check("post_rst_len", 32'(d0_len), 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 8) f = 3'b001 << $urandom_range(0, 2);
      else f = 3'($urandom);
      step(bit'($urandom_range(0, 9) < 8), f[0], f[1], f[2], bit'($urandom_range(0, 39) == 0),
           bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
# cmp_result_tracker

Downstream consumer of the single-bit comparator stage: samples its `gt`/`ls`/`eq` result each valid cycle, keeps saturating per-outcome counters, tracks the length of the current run of identical outcomes, and flags malformed (non-one-hot) results. A req/ack snapshot port hands a coherent copy of all three counters to a slower reader without stalling the sampling path.

## Interface
Parameters:
- `CNT_W`, 8: width of each outcome counter and of `run_len`.
- `RUN_THR`, 4: run length at or above which `run_hit` asserts; legal range 1..2^CNT_W-1.
- `CLR_ON_SNAP`, 0: if 1, live counters are zeroed at snapshot capture.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `gt`/`ls`/`eq` carry a result this cycle.
- `gt`, `ls`, `eq`  in  1 each  comparator result flags.
- `clr`  in  1  synchronous clear of counters, run state, `err`.
- `snap_req`  in  1  request a snapshot (sampled in IDLE only).
- `snap_ready`  in  1  reader accepts the held snapshot.
- `gt_cnt`, `ls_cnt`, `eq_cnt`  out  CNT_W each  snapshot counter values.
- `snap_valid`  out  1  snapshot held and valid.
- `run_len`  out  CNT_W  length of current run of identical outcomes.
- `run_hit`  out  1  `run_len >= RUN_THR`.
- `err`  out  1  sticky: a non-one-hot result was seen with `in_valid`.

## Operation
- Sample accepted when `in_valid=1` and exactly one of `gt`,`ls`,`eq` is 1; the matching live counter increments by 1, saturating at 2^CNT_W-1 (holds, no wrap).
- `in_valid=1` with zero or ≥2 flags set: sample dropped, `err` set to 1 and held until `clr` or reset; counters and run state unchanged.
- `in_valid=0`: flags ignored, nothing changes.
- Run state: class register {NONE, GT, LS, EQ}, reset to NONE. Accepted sample of same class as current: `run_len` increments, saturating. Different class (or NONE): class updated, `run_len` = 1.
- `run_hit` = registered `run_len_next >= RUN_THR`; tracks `run_len` on the same edge.
- `clr=1`: live counters, `run_len`, class (NONE), `run_hit`, `err` all zeroed next edge; any same-cycle sample is dropped (clr wins). Snapshot FSM and snapshot registers unaffected.
- Snapshot FSM, states IDLE, HOLD:
  - IDLE, `snap_req=1`: capture live counter *next* values (includes a sample accepted that same cycle; reflects `clr` if asserted) into `gt_cnt`/`ls_cnt`/`eq_cnt`; go HOLD.
  - HOLD: `snap_valid=1`; outputs frozen; `snap_req` ignored. `snap_ready=1` -> IDLE.
  - IDLE: `snap_valid=0`; snapshot outputs keep last captured values.
  - `CLR_ON_SNAP=1`: on capture, live counters load 0; the same-cycle sample is counted in the snapshot only. Run state is never cleared by snapshot.
- Live counters keep sampling in both FSM states.

## Timing
- Reset (async assert, released synchronously by the system): all counters, snapshot regs, `run_len` = 0; class NONE; `run_hit`, `err`, `snap_valid` = 0; FSM IDLE.
- Reset mid-HOLD: `snap_valid` drops immediately (asynchronous), snapshot lost.
- Sample -> live counter / `run_len` / `run_hit` / `err`: 1 cycle.
- `snap_req` -> `snap_valid`: 1 cycle. `snap_ready` in HOLD -> `snap_valid` low next edge. Minimum request-to-request turnaround: 2 cycles (req, ready same cycle as valid, new req next cycle).
- `snap_ready` in IDLE: no effect.
- Counter at saturation plus accepted sample: value holds; no other side effect.

## Test plan
- Reset, then 3 accepted `gt`, 2 `eq`, 1 `ls`, then `snap_req` -> next cycle `snap_valid=1`, `gt_cnt=3`, `eq_cnt=2`, `ls_cnt=1`; `snap_ready` -> `snap_valid=0` next cycle.
- 5 consecutive accepted `eq` with RUN_THR=4 -> `run_len` 1,2,3,4,5; `run_hit` rises with `run_len=4`; next `gt` -> `run_len=1`, `run_hit=0`.
- `in_valid=1` with `gt=ls=1`, then with all flags 0 -> `err=1` and stays; counters and `run_len` unchanged; `clr` -> `err=0`, all live state 0.
- CNT_W=8: 257 accepted `ls` -> snapshot `ls_cnt=255`, `run_len=255`.
- `snap_req` in same cycle as accepted `gt` (live gt=6) -> `gt_cnt=7`; with CLR_ON_SNAP=1 live counters restart at 0; further `snap_req` during HOLD ignored, snapshot stays 7.
- Assert `rst` low while HOLD and mid-run -> `snap_valid`, `run_hit`, all counters 0 immediately; after release first accepted `eq` gives `run_len=1`.
